// File: rtl/and_gate.sv
// Registered (or combinational) three-input bitwise AND with a valid strobe.
// Optional saturating all-ones counter enabled by defining AND_GATE_STATS_EN.
module and_gate #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             all_ones
`ifdef AND_GATE_STATS_EN
  ,
  output logic [15:0]      hi_count
`endif
);

  logic [WIDTH-1:0] and_res;

  assign and_res  = a & b & c;
  assign all_ones = &y;

  generate
    if (OUT_REG) begin : g_reg
      logic [WIDTH-1:0] y_q;
      logic [WIDTH-1:0] y_d;
      logic             valid_q;
      logic             valid_d;

      // y holds its last result while no sample is presented
      always_comb begin
        y_d     = y_q;
        valid_d = 1'b0;
        if (in_valid) begin
          y_d     = and_res;
          valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          y_q     <= '0;
          valid_q <= 1'b0;
        end else begin
          y_q     <= y_d;
          valid_q <= valid_d;
        end
      end

      assign y         = y_q;
      assign out_valid = valid_q;
    end else begin : g_comb
      assign y         = rst ? '0 : and_res;
      assign out_valid = in_valid & ~rst;
    end
  endgenerate

`ifdef AND_GATE_STATS_EN
  logic [15:0] hi_count_q;
  logic [15:0] hi_count_d;

  // Saturates at all ones instead of wrapping
  always_comb begin
    hi_count_d = hi_count_q;
    if (in_valid && (&and_res) && (hi_count_q != 16'hFFFF)) begin
      hi_count_d = hi_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_count_q <= '0;
    end else begin
      hi_count_q <= hi_count_d;
    end
  end

  assign hi_count = hi_count_q;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: a WIDTH=1 registered instance and a WIDTH=4 combinational instance.
// Checks hi_count as well when built with AND_GATE_STATS_EN.
module tb_and_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       a1, b1, c1;
  logic [3:0] a4, b4, c4;
  logic       y1, vld1, ones1;
  logic [3:0] y4;
  logic       vld4, ones4;
`ifdef AND_GATE_STATS_EN
  logic [15:0] hi1, hi4;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state for the registered instance
  logic [31:0] exp_y1;
  logic [31:0] exp_vld1;
  int          exp_hi;

  always #5 clk = ~clk;

  and_gate #(.WIDTH(1), .OUT_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a1), .b(b1), .c(c1),
    .y(y1), .out_valid(vld1), .all_ones(ones1)
`ifdef AND_GATE_STATS_EN
    , .hi_count(hi1)
`endif
  );

  and_gate #(.WIDTH(4), .OUT_REG(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a4), .b(b4), .c(c4),
    .y(y4), .out_valid(vld4), .all_ones(ones4)
`ifdef AND_GATE_STATS_EN
    , .hi_count(hi4)
`endif
  );

  // Bitwise three-way AND computed one bit at a time with multiplication
  function automatic logic [31:0] refAnd(input int x, input int yy, input int z, input int width);
    int r = 0;
    for (int i = 0; i < width; i++) begin
      r += (((x >> i) & 1) * ((yy >> i) & 1) * ((z >> i) & 1)) << i;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check the combinational instance, then the registered one after the edge
  task automatic applyStimulus(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc,
                               input logic vv, input logic vr);
    logic [31:0] e4;
    logic [31:0] e1;
    @(negedge clk);
    a4 = va; b4 = vb; c4 = vc;
    a1 = va[0]; b1 = vb[0]; c1 = vc[0];
    in_valid = vv;
    rst = vr;
    #1;
    e4 = vr ? 32'd0 : refAnd(int'(va), int'(vb), int'(vc), 4);
    checkOutput("y4", {28'd0, y4}, e4);
    checkOutput("vld4", {31'd0, vld4}, {31'd0, vv && !vr});
    checkOutput("ones4", {31'd0, ones4}, {31'd0, e4 == 32'hF});
    e1 = refAnd(int'(va[0]), int'(vb[0]), int'(vc[0]), 1);
    @(posedge clk);
    if (vr) begin
      exp_y1 = 0; exp_vld1 = 0; exp_hi = 0;
    end else if (vv) begin
      exp_y1 = e1; exp_vld1 = 1;
      if (e1 == 1 && exp_hi < 65535) exp_hi++;
    end else begin
      exp_vld1 = 0;
    end
    #1;
    checkOutput("y1", {31'd0, y1}, exp_y1);
    checkOutput("vld1", {31'd0, vld1}, exp_vld1);
    checkOutput("ones1", {31'd0, ones1}, {31'd0, exp_y1 == 1});
`ifdef AND_GATE_STATS_EN
    checkOutput("hi1", {16'd0, hi1}, exp_hi);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    a1 = 0; b1 = 0; c1 = 0; a4 = 0; b4 = 0; c4 = 0;
    exp_y1 = 0; exp_vld1 = 0; exp_hi = 0;

    // Reset for two cycles, then idle
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Back-to-back samples 000, 011, 111, 101
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h1, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'h1, 4'h1, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'h1, 4'h0, 4'h1, 1'b1, 1'b0);

    // Result of 1, then in_valid low holds y
    applyStimulus(4'h1, 4'h1, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Reset beats a 111 sample in the same cycle
    applyStimulus(4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Wide combinational case F & A & E
    applyStimulus(4'hF, 4'hA, 4'hE, 1'b1, 1'b0);

    // Three 111 and two 011 samples after a clean reset
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    applyStimulus(4'h1, 4'h1, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h1, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'h1, 4'h1, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h1, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'hF, 4'hF, 4'hF, 1'b1, 1'b0);

`ifdef AND_GATE_STATS_EN
    checkOutput("hi_after_five", {16'd0, hi1}, 32'd3);
    // Preload the counter at its ceiling and confirm it saturates
    @(negedge clk);
    force dut1.hi_count_q = 16'hFFFF;
    #1;
    release dut1.hi_count_q;
    exp_hi = 65535;
    applyStimulus(4'h1, 4'h1, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
`endif

    // Random traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      logic [3:0] ra, rb, rc;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        ra = ra | 4'h9; rb = rb | 4'h9; rc = rc | 4'h9;
      end
      applyStimulus(ra, rb, rc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
